ring_merge4x2: RTL and testbench

RING_MERGE4X2 -- requirements
Module: ring_merge4x2

---
 rtl/ring_merge4x2_if.sv | 40 ++++
 rtl/ring_merge4x2.sv | 137 +++++++++++++
 tb/tb_ring_merge4x2.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ring_merge4x2_if.sv
`default_nettype none
// ============================================================================
//  Module   : ring_merge4x2_if
//  Brief    : Bundle of the four local-side flit inputs with their stalls and
//             the two ring-side flit outputs with their downstream stalls.
//  Revision : 1.0  initial release
// ============================================================================
interface ring_merge4x2_if #(
    parameter int WIDTH = 144
);
    logic [WIDTH-1:0] portl0_ci;
    logic [WIDTH-1:0] portl1_ci;
    logic [WIDTH-1:0] portl2_ci;
    logic [WIDTH-1:0] portl3_ci;
    logic             portl0_stall;
    logic             portl1_stall;
    logic             portl2_stall;
    logic             portl3_stall;
    logic [WIDTH-1:0] port0_co;
    logic [WIDTH-1:0] port1_co;
    logic             port0_stall_i;
    logic             port1_stall_i;

    // Merger side
    modport slave (
        input  portl0_ci, portl1_ci, portl2_ci, portl3_ci,
        input  port0_stall_i, port1_stall_i,
        output portl0_stall, portl1_stall, portl2_stall, portl3_stall,
        output port0_co, port1_co
    );

    // Local senders / ring consumer side
    modport master (
        output portl0_ci, portl1_ci, portl2_ci, portl3_ci,
        output port0_stall_i, port1_stall_i,
        input  portl0_stall, portl1_stall, portl2_stall, portl3_stall,
        input  port0_co, port1_co
    );
endinterface
`default_nettype wire

// File: rtl/ring_merge4x2.sv
`default_nettype none
// ============================================================================
//  Module   : ring_merge4x2
//  Brief    : Merges four local flit inputs onto two ring outputs. Each input
//             owns a small FIFO; each output runs its own round-robin arbiter
//             over the FIFO heads addressed to it.
//  Revision : 1.0  initial release
// ============================================================================
module ring_merge4x2 #(
    parameter int VALID_BIT = 143,
    parameter int RING_BIT  = 142,
    parameter int DEPTH     = 2,      // 2 or 4; pointers wrap naturally
    parameter int WIDTH     = 144     // width of one control word
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ring_merge4x2_if.slave  bus
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;

    logic [WIDTH-1:0] ci       [4];
    logic [1:0]       stall_in;
    logic [WIDTH-1:0] head     [4];
    logic [3:0]       enq;
    logic [3:0]       deq;

    logic [WIDTH-1:0] mem_q    [4][DEPTH];
    logic [WIDTH-1:0] mem_d    [4][DEPTH];
    logic [PW-1:0]    rd_ptr_q [4];
    logic [PW-1:0]    rd_ptr_d [4];
    logic [PW-1:0]    wr_ptr_q [4];
    logic [PW-1:0]    wr_ptr_d [4];
    logic [2:0]       count_q  [4];
    logic [2:0]       count_d  [4];
    logic [3:0]       stall_q;
    logic [3:0]       stall_d;
    logic [WIDTH-1:0] co_q     [2];
    logic [WIDTH-1:0] co_d     [2];
    logic [1:0]       rr_q     [2];
    logic [1:0]       rr_d     [2];

    assign ci[0]       = bus.portl0_ci;
    assign ci[1]       = bus.portl1_ci;
    assign ci[2]       = bus.portl2_ci;
    assign ci[3]       = bus.portl3_ci;
    assign stall_in[0] = bus.port0_stall_i;
    assign stall_in[1] = bus.port1_stall_i;

    assign bus.portl0_stall = stall_q[0];
    assign bus.portl1_stall = stall_q[1];
    assign bus.portl2_stall = stall_q[2];
    assign bus.portl3_stall = stall_q[3];
    assign bus.port0_co     = co_q[0];
    assign bus.port1_co     = co_q[1];

    // Per-output round-robin arbitration and output register loading
    always_comb begin
        logic       free;
        logic       found;
        logic [1:0] gnt;
        logic [1:0] idx;
        deq = '0;
        for (int r = 0; r < 2; r++) begin
            co_d[r] = co_q[r];
            rr_d[r] = rr_q[r];
            free    = !co_q[r][VALID_BIT] || !stall_in[r];
            found   = 1'b0;
            gnt     = 2'd0;
            for (int k = 0; k < 4; k++) begin
                idx = rr_q[r] + 2'(k);
                if (!found && (count_q[idx] != 3'd0) &&
                    (head[idx][RING_BIT] == 1'(r))) begin
                    found = 1'b1;
                    gnt   = idx;
                end
            end
            if (free) begin
                if (found) begin
                    co_d[r]  = head[gnt];
                    deq[gnt] = 1'b1;
                    rr_d[r]  = gnt + 2'd1;
                end else begin
                    co_d[r]  = '0;
                end
            end
        end
    end

    // Per-input FIFO bookkeeping; stall reflects the post-edge fill level
    always_comb begin
        mem_d = mem_q;
        for (int n = 0; n < 4; n++) begin
            head[n]     = mem_q[n][rd_ptr_q[n]];
            enq[n]      = ci[n][VALID_BIT] && !stall_q[n];
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            if (enq[n]) begin
                mem_d[n][wr_ptr_q[n]] = ci[n];
                wr_ptr_d[n]           = wr_ptr_q[n] + PW'(1);
            end
            if (deq[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + PW'(1);
            end
            count_d[n] = count_q[n] + {2'b00, enq[n]} - {2'b00, deq[n]};
            stall_d[n] = (count_d[n] == 3'(DEPTH));
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                rd_ptr_q[n] <= '0;
                wr_ptr_q[n] <= '0;
                count_q[n]  <= '0;
            end
            stall_q <= '0;
            for (int r = 0; r < 2; r++) begin
                co_q[r] <= '0;
                rr_q[r] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            co_q     <= co_d;
            rr_q     <= rr_d;
        end
    end

    // FIFO storage; contents are only meaningful below the count, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_ring_merge4x2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_merge4x2
//  Brief    : Directed scoreboard bench for ring_merge4x2.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ring_merge4x2;
    localparam int W = 144;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ring_merge4x2_if #(.WIDTH(W)) bus ();

    ring_merge4x2 #(
        .VALID_BIT(143), .RING_BIT(142), .DEPTH(2), .WIDTH(W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp0 [$];
    logic [W-1:0] exp1 [$];

    function automatic logic [W-1:0] mk(input logic ring, input logic [15:0] pl);
        logic [W-1:0] f;
        f      = '0;
        f[143] = 1'b1;
        f[142] = ring;
        f[15:0] = pl;
        return f;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: a valid flit with no downstream stall is consumed
    task automatic mon_port(input int r, input logic [W-1:0] v, input logic st);
        logic [W-1:0] e;
        if (!v[143]) begin
            chk($sformatf("idle_zero%0d", r), v, '0);
        end else if (!st) begin
            if ((r == 0 && exp0.size() == 0) || (r == 1 && exp1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit%0d actual=%h required=none", r, v);
            end else begin
                e = (r == 0) ? exp0.pop_front() : exp1.pop_front();
                chk($sformatf("flit%0d", r), v, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_port(0, bus.port0_co, bus.port0_stall_i);
            mon_port(1, bus.port1_co, bus.port1_stall_i);
        end
    end

    task automatic clear_inputs();
        bus.portl0_ci = '0;
        bus.portl1_ci = '0;
        bus.portl2_ci = '0;
        bus.portl3_ci = '0;
    endtask

    initial begin
        int   k;
        int   cyc;
        logic s;
        logic seen;

        clear_inputs();
        bus.port0_stall_i = 1'b0;
        bus.port1_stall_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_co0", bus.port0_co, '0);
        chk("rst_co1", bus.port1_co, '0);
        chk("rst_stalls", {140'd0, bus.portl3_stall, bus.portl2_stall,
                           bus.portl1_stall, bus.portl0_stall}, '0);
        rst = 1'b0;

        // Single flit from local 2 to ring 1
        bus.portl2_ci = mk(1'b1, 16'h1852);
        exp1.push_back(mk(1'b1, 16'h1852));
        tick();
        bus.portl2_ci = '0;
        chk("single_edge1", bus.port1_co, '0);
        tick();
        chk("single_edge2", bus.port1_co, mk(1'b1, 16'h1852));
        chk("single_co0", bus.port0_co, '0);
        tick();
        chk("single_after", bus.port1_co, '0);
        tick();

        // Round robin: all four contend for ring 0
        bus.portl0_ci = mk(1'b0, 16'h1850);
        bus.portl1_ci = mk(1'b0, 16'h1851);
        bus.portl2_ci = mk(1'b0, 16'h1852);
        bus.portl3_ci = mk(1'b0, 16'h1853);
        for (int i = 0; i < 4; i++) exp0.push_back(mk(1'b0, 16'h1850 + 16'(i)));
        tick();
        clear_inputs();
        repeat (6) tick();
        // Pointer back at 0: local 1 before local 3
        bus.portl1_ci = mk(1'b0, 16'h1861);
        bus.portl3_ci = mk(1'b0, 16'h1863);
        exp0.push_back(mk(1'b0, 16'h1861));
        exp0.push_back(mk(1'b0, 16'h1863));
        tick();
        clear_inputs();
        repeat (4) tick();
        // Single grant to local 2 moves the pointer to 3
        bus.portl2_ci = mk(1'b0, 16'h1872);
        exp0.push_back(mk(1'b0, 16'h1872));
        tick();
        clear_inputs();
        repeat (3) tick();
        // From pointer 3: local 3 before local 0
        bus.portl0_ci = mk(1'b0, 16'h1880);
        bus.portl3_ci = mk(1'b0, 16'h1883);
        exp0.push_back(mk(1'b0, 16'h1883));
        exp0.push_back(mk(1'b0, 16'h1880));
        tick();
        clear_inputs();
        repeat (4) tick();

        // Parallel: both rings served in the same cycle
        bus.portl0_ci = mk(1'b0, 16'h1900);
        bus.portl3_ci = mk(1'b1, 16'h1903);
        exp0.push_back(mk(1'b0, 16'h1900));
        exp1.push_back(mk(1'b1, 16'h1903));
        tick();
        clear_inputs();
        tick();
        chk("par_co0", bus.port0_co, mk(1'b0, 16'h1900));
        chk("par_co1", bus.port1_co, mk(1'b1, 16'h1903));
        repeat (3) tick();

        // Backpressure: ring 0 stalled for 5 cycles while local 1 streams
        bus.port0_stall_i = 1'b1;
        k    = 0;
        cyc  = 0;
        seen = 1'b0;
        while (k < 6 && cyc < 60) begin
            bus.portl1_ci = mk(1'b0, 16'h2000 + 16'(k));
            s = bus.portl1_stall;
            if (s) seen = 1'b1;
            tick();
            if (!s) begin
                exp0.push_back(mk(1'b0, 16'h2000 + 16'(k)));
                k++;
            end
            cyc++;
            if (cyc == 5) begin
                chk("bp_hold", bus.port0_co, mk(1'b0, 16'h2000));
                bus.port0_stall_i = 1'b0;
            end
        end
        if (k < 6) begin
            total++;
            bad++;
            $display("FAIL bp_stream actual=%0d required=6", k);
        end
        bus.portl1_ci = '0;
        chk("bp_stall_seen", {143'd0, seen}, {143'd0, 1'b1});
        repeat (8) tick();

        // Reset mid-stream with buffered flits on ring 0
        bus.port0_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.portl0_ci = mk(1'b0, 16'h3000 + 16'(i));
            tick();
        end
        bus.portl0_ci = '0;
        chk("pre_rst_stall", {143'd0, bus.portl0_stall}, {143'd0, 1'b1});
        rst = 1'b1;
        bus.portl2_ci = mk(1'b1, 16'h3333);
        tick();
        rst = 1'b0;
        bus.portl2_ci = '0;
        chk("post_rst_co0", bus.port0_co, '0);
        chk("post_rst_co1", bus.port1_co, '0);
        chk("post_rst_stall0", {143'd0, bus.portl0_stall}, '0);
        bus.port0_stall_i = 1'b0;
        bus.portl1_ci = mk(1'b1, 16'h3101);
        exp1.push_back(mk(1'b1, 16'h3101));
        tick();
        bus.portl1_ci = '0;
        repeat (6) tick();

        // Drain with a bounded wait
        cyc = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && cyc < 50) begin
            tick();
            cyc++;
        end
        if (exp0.size() != 0 || exp1.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d/%0d required=0/0", exp0.size(), exp1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
